// File: rtl/out_port_fifo_if.sv
// Bus bundle between the CPU-side OUT datapath / external device and the
// buffered output port. The slave modport is the FIFO's view; the master
// modport is the view of whatever drives writes and acknowledges words.
interface out_port_fifo_if #(
    parameter int WIDTH = 32,
    parameter int AW    = 2
);
    logic [WIDTH-1:0] BusMuxOut;
    logic             Out_Portin;
    logic [WIDTH-1:0] OUTPUT_UNIT;
    logic             Out_Valid;
    logic             Out_Ack;
    logic             Out_Full;
    logic [AW:0]      Out_Count;
    logic             Overflow;
    logic             Ovf_clr;

    modport slave (
        input  BusMuxOut,
        input  Out_Portin,
        input  Out_Ack,
        input  Ovf_clr,
        output OUTPUT_UNIT,
        output Out_Valid,
        output Out_Full,
        output Out_Count,
        output Overflow
    );

    modport master (
        output BusMuxOut,
        output Out_Portin,
        output Out_Ack,
        output Ovf_clr,
        input  OUTPUT_UNIT,
        input  Out_Valid,
        input  Out_Full,
        input  Out_Count,
        input  Overflow
    );
endinterface

// File: rtl/out_port_fifo.sv
// Buffered output port: captures OUT-instruction words from the internal bus
// into a small FIFO and presents them to an external device under a
// valid/acknowledge handshake. The head word and its valid flag are flops
// loaded with the post-edge head, so the device sees no combinational path
// from the storage array or from the CPU-side inputs.
module out_port_fifo #(
    parameter int WIDTH = 32,
    parameter int DEPTH = 4,
    parameter int AW    = 2
) (
    input  logic            clock,
    input  logic            clear,
    out_port_fifo_if.slave  bus
);

    localparam logic [AW:0] DEPTH_C = (AW+1)'(DEPTH);

    // Storage: not reset, only the pointers/count define what is valid.
    logic [WIDTH-1:0] mem [DEPTH];

    logic [AW-1:0]    wr_ptr;
    logic [AW-1:0]    rd_ptr;
    logic [AW-1:0]    rd_next;
    logic [AW:0]      count;
    logic [AW:0]      count_next;
    logic [WIDTH-1:0] head_word;
    logic [WIDTH-1:0] out_unit;
    logic             out_valid;
    logic             overflow;
    logic             push;
    logic             pop;

    // Handshake events, next-count and the word that will be at the head after this edge.
    always_comb begin
        pop  = bus.Out_Ack & out_valid;
        // A pop in the same edge frees a slot, so a full FIFO can still accept.
        push = bus.Out_Portin & ((count != DEPTH_C) | pop);

        count_next = count;
        case ({push, pop})
            2'b10:   count_next = count + 1'b1;
            2'b01:   count_next = count - 1'b1;
            default: count_next = count;
        endcase

        rd_next = pop ? rd_ptr + 1'b1 : rd_ptr;

        // The incoming word lands exactly at the new head only when the FIFO
        // is empty after any pop; bypass it so the head flop sees it now.
        if (push && (wr_ptr == rd_next))
            head_word = bus.BusMuxOut;
        else
            head_word = mem[rd_next];
    end

    // Storage write on an accepted push.
    always_ff @(posedge clock) begin
        if (push)
            mem[wr_ptr] <= bus.BusMuxOut;
    end

    // Pointers and occupancy count; pointers wrap naturally at DEPTH.
    always_ff @(posedge clock or negedge clear) begin
        if (!clear) begin
            wr_ptr <= '0;
            rd_ptr <= '0;
            count  <= '0;
        end else begin
            if (push)
                wr_ptr <= wr_ptr + 1'b1;
            rd_ptr <= rd_next;
            count  <= count_next;
        end
    end

    // Registered head word and valid; the word holds its last value when empty.
    always_ff @(posedge clock or negedge clear) begin
        if (!clear) begin
            out_unit  <= '0;
            out_valid <= 1'b0;
        end else begin
            out_valid <= (count_next != '0);
            if (count_next != '0)
                out_unit <= head_word;
        end
    end

    // Sticky overflow: a dropped write sets it, and setting beats clearing.
    always_ff @(posedge clock or negedge clear) begin
        if (!clear)
            overflow <= 1'b0;
        else if (bus.Out_Portin && !push)
            overflow <= 1'b1;
        else if (bus.Ovf_clr)
            overflow <= 1'b0;
    end

    assign bus.OUTPUT_UNIT = out_unit;
    assign bus.Out_Valid   = out_valid;
    assign bus.Out_Count   = count;
    assign bus.Out_Full    = (count == DEPTH_C);
    assign bus.Overflow    = overflow;

endmodule

// File: tb/tb_out_port_fifo.sv
// Self-checking bench for out_port_fifo: directed scenarios followed by
// randomized traffic, compared against a queue-based reference model, with a
// scoreboard monitor checking every word the device consumes.
module tb_out_port_fifo;

    localparam int DEPTH = 4;

    logic clock;
    logic clear;

    out_port_fifo_if #(.WIDTH(32), .AW(2)) bus_if ();

    out_port_fifo #(.WIDTH(32), .DEPTH(DEPTH), .AW(2)) dut (
        .clock (clock),
        .clear (clear),
        .bus   (bus_if.slave)
    );

    initial clock = 1'b0;
    always #5 clock = ~clock;

    int n_checks = 0;
    int n_pass   = 0;

    // Reference model state
    logic [31:0] m_q[$];      // words held in the FIFO
    logic [31:0] exp_q[$];    // scoreboard: accepted words, awaiting consumption
    logic [31:0] drained_q[$];
    logic        m_ovf;
    logic [31:0] m_head;
    bit          m_pop;
    bit          m_push;

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_checks++;
        if (act === exp)
            n_pass++;
        else
            $display("FAIL %s: got %h expected %h (t=%0t)", name, act, exp, $time);
    endtask

    // Reference model: FIFO rules applied to a queue at each rising edge.
    always @(posedge clock or negedge clear) begin
        if (!clear) begin
            m_q.delete();
            exp_q.delete();
            m_ovf  = 1'b0;
            m_head = '0;
        end else begin
            m_pop  = bus_if.Out_Ack && (m_q.size() > 0);
            m_push = bus_if.Out_Portin && ((m_q.size() < DEPTH) || m_pop);
            if (m_pop)
                void'(m_q.pop_front());
            if (m_push) begin
                m_q.push_back(bus_if.BusMuxOut);
                exp_q.push_back(bus_if.BusMuxOut);
            end
            if (bus_if.Out_Portin && !m_push)
                m_ovf = 1'b1;
            else if (bus_if.Ovf_clr)
                m_ovf = 1'b0;
            if (m_q.size() > 0)
                m_head = m_q[0];
        end
    end

    // Scoreboard monitor: each consumed word must be the oldest accepted one.
    always @(posedge clock) begin
        if (clear && bus_if.Out_Valid && bus_if.Out_Ack) begin
            logic [31:0] w;
            n_checks++;
            if (exp_q.size() == 0) begin
                $display("FAIL consume: got %h expected no word (t=%0t)", bus_if.OUTPUT_UNIT, $time);
            end else begin
                w = exp_q.pop_front();
                if (bus_if.OUTPUT_UNIT === w)
                    n_pass++;
                else
                    $display("FAIL consume: got %h expected %h (t=%0t)", bus_if.OUTPUT_UNIT, w, $time);
            end
            drained_q.push_back(bus_if.OUTPUT_UNIT);
        end
    end

    task automatic check_state();
        chk("count", 32'(bus_if.Out_Count), 32'(m_q.size()));
        chk("valid", 32'(bus_if.Out_Valid), 32'(m_q.size() > 0));
        chk("full",  32'(bus_if.Out_Full),  32'(m_q.size() == DEPTH));
        chk("ovf",   32'(bus_if.Overflow),  32'(m_ovf));
        chk("head",  bus_if.OUTPUT_UNIT,    m_head);
    endtask

    // One clock: drive inputs (called at a falling edge), then check at the next falling edge.
    task automatic step(input bit p, input logic [31:0] d, input bit a, input bit oc);
        bus_if.Out_Portin = p;
        bus_if.BusMuxOut  = d;
        bus_if.Out_Ack    = a;
        bus_if.Ovf_clr    = oc;
        @(posedge clock);
        @(negedge clock);
        check_state();
    endtask

    task automatic chk_drained(input string name, input logic [31:0] exp[$]);
        chk({name, "_len"}, 32'(drained_q.size()), 32'(exp.size()));
        for (int i = 0; i < exp.size(); i++)
            chk(name, (i < drained_q.size()) ? drained_q[i] : 32'hxxxx_xxxx, exp[i]);
    endtask

    initial begin
        bus_if.Out_Portin = 1'b0;
        bus_if.BusMuxOut  = '0;
        bus_if.Out_Ack    = 1'b0;
        bus_if.Ovf_clr    = 1'b0;
        clear = 1'b0;
        @(negedge clock);
        @(negedge clock);
        check_state();
        chk("rst_out", bus_if.OUTPUT_UNIT, 32'h0);
        chk("rst_cnt", 32'(bus_if.Out_Count), 32'd0);
        clear = 1'b1;

        // Single write, one-cycle latency, then one ack empties it.
        step(1, 32'h13868904, 0, 0);
        chk("t1_out", bus_if.OUTPUT_UNIT, 32'h13868904);
        chk("t1_valid", 32'(bus_if.Out_Valid), 32'd1);
        chk("t1_cnt", 32'(bus_if.Out_Count), 32'd1);
        step(0, 0, 1, 0);
        chk("t1_valid_after_ack", 32'(bus_if.Out_Valid), 32'd0);
        chk("t1_cnt_after_ack", 32'(bus_if.Out_Count), 32'd0);

        // Ordering and pointer wrap-around.
        drained_q.delete();
        step(1, 32'h11, 0, 0);
        step(1, 32'h22, 0, 0);
        step(1, 32'h33, 0, 0);
        chk("t2_not_full", 32'(bus_if.Out_Full), 32'd0);
        step(1, 32'h44, 0, 0);
        chk("t2_full", 32'(bus_if.Out_Full), 32'd1);
        repeat (4) step(0, 0, 1, 0);
        step(1, 32'h55, 0, 0);
        step(1, 32'h66, 0, 0);
        repeat (2) step(0, 0, 1, 0);
        chk_drained("t2_order", '{32'h11, 32'h22, 32'h33, 32'h44, 32'h55, 32'h66});

        // Overflow: dropped write, set beats clear, then clear.
        drained_q.delete();
        step(1, 32'hA1, 0, 0);
        step(1, 32'hA2, 0, 0);
        step(1, 32'hA3, 0, 0);
        step(1, 32'hA4, 0, 0);
        step(1, 32'hDEAD, 0, 0);
        chk("t3_cnt", 32'(bus_if.Out_Count), 32'd4);
        chk("t3_ovf", 32'(bus_if.Overflow), 32'd1);
        step(1, 32'hBAD2, 0, 1);
        chk("t3_set_wins", 32'(bus_if.Overflow), 32'd1);
        repeat (4) step(0, 0, 1, 0);
        chk_drained("t3_data", '{32'hA1, 32'hA2, 32'hA3, 32'hA4});
        step(0, 0, 0, 1);
        chk("t3_ovf_clr", 32'(bus_if.Overflow), 32'd0);

        // Simultaneous push and pop at full and at count=1.
        drained_q.delete();
        step(1, 32'hB1, 0, 0);
        step(1, 32'hB2, 0, 0);
        step(1, 32'hB3, 0, 0);
        step(1, 32'hB4, 0, 0);
        step(1, 32'hBEEF, 1, 0);
        chk("t4_cnt", 32'(bus_if.Out_Count), 32'd4);
        chk("t4_full", 32'(bus_if.Out_Full), 32'd1);
        chk("t4_head", bus_if.OUTPUT_UNIT, 32'hB2);
        chk("t4_ovf", 32'(bus_if.Overflow), 32'd0);
        repeat (4) step(0, 0, 1, 0);
        chk_drained("t4_data", '{32'hB1, 32'hB2, 32'hB3, 32'hB4, 32'hBEEF});
        step(1, 32'hC1, 0, 0);
        step(1, 32'hC2, 1, 0);
        chk("t4b_valid", 32'(bus_if.Out_Valid), 32'd1);
        chk("t4b_cnt", 32'(bus_if.Out_Count), 32'd1);
        chk("t4b_head", bus_if.OUTPUT_UNIT, 32'hC2);
        step(0, 0, 1, 0);

        // Stall hold and spurious ack.
        step(1, 32'hD1, 0, 0);
        step(1, 32'hD2, 0, 0);
        chk("t5_hold1", bus_if.OUTPUT_UNIT, 32'hD1);
        step(1, 32'hD3, 0, 0);
        chk("t5_hold2", bus_if.OUTPUT_UNIT, 32'hD1);
        repeat (3) step(0, 0, 1, 0);
        step(0, 0, 1, 0);
        chk("t5_spurious_cnt", 32'(bus_if.Out_Count), 32'd0);
        chk("t5_spurious_valid", 32'(bus_if.Out_Valid), 32'd0);

        // Asynchronous reset between edges with 3 words buffered.
        step(1, 32'hE1, 0, 0);
        step(1, 32'hE2, 0, 0);
        step(1, 32'hE3, 0, 0);
        bus_if.Out_Portin = 1'b0;
        #2 clear = 1'b0;
        #1;
        chk("t6_valid", 32'(bus_if.Out_Valid), 32'd0);
        chk("t6_cnt", 32'(bus_if.Out_Count), 32'd0);
        chk("t6_ovf", 32'(bus_if.Overflow), 32'd0);
        chk("t6_out", bus_if.OUTPUT_UNIT, 32'h0);
        @(negedge clock);
        clear = 1'b1;
        drained_q.delete();
        step(1, 32'h77, 0, 0);
        chk("t6_new_head", bus_if.OUTPUT_UNIT, 32'h77);
        step(0, 0, 1, 0);
        chk_drained("t6_first", '{32'h77});

        // Randomized traffic against the reference model.
        for (int i = 0; i < 600; i++) begin
            step(($urandom_range(0, 99) < 55), $urandom,
                 ($urandom_range(0, 99) < 45), ($urandom_range(0, 99) < 8));
        end
        repeat (DEPTH + 1) step(0, 0, 1, 0);
        chk("final_cnt", 32'(bus_if.Out_Count), 32'd0);

        $display("%0d/%0d checks passed", n_pass, n_checks);
        $finish;
    end

endmodule
